// File: rtl/traffic_sched.sv
// Pedestrian/rush sequencer for the two-road traffic-light fsm.
// Optional emergency override is compiled in with `define TRAFFIC_SCHED_EMERG_EN.
module traffic_sched #(
  parameter int CNT_W    = 8,
  parameter int WALK_CYC = 8,
  parameter int COOL_CYC = 4,
  parameter int WAIT_MAX = 32,
  parameter int RUSH_MIN = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ped_req_a,
  input  logic       i_ped_req_b,
  input  logic       i_rush_req,
`ifdef TRAFFIC_SCHED_EMERG_EN
  input  logic       i_emerg,
`endif
  input  logic [1:0] i_light_a,
  input  logic [1:0] i_light_b,
  output logic       o_mode_p,
  output logic       o_mode_r,
  output logic       o_walk_a,
  output logic       o_walk_b,
  output logic       o_ack_a,
  output logic       o_ack_b,
  output logic       o_busy,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PED_WAIT = 3'd1,
    S_PED_WALK = 3'd2,
    S_RUSH     = 3'd3,
    S_COOL     = 3'd4,
    S_EMERG    = 3'd5
  } state_t;

  localparam logic [1:0]       LIGHT_RED = 2'b00;
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'(COOL_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] RUSH_LD   = CNT_W'(RUSH_MIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic             grant;   // 0 = crosswalk A, 1 = crosswalk B
  logic             rr_ptr;
  logic             pend_a;
  logic             pend_b;
  logic             ack_q;
  logic [CNT_W-1:0] count;
  logic [1:0]       light_sel;
  logic             any_pend;

  assign light_sel = grant ? i_light_b : i_light_a;
  assign any_pend  = pend_a | pend_b;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= S_IDLE;
      grant  <= 1'b0;
      rr_ptr <= 1'b0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      ack_q  <= 1'b0;
      count  <= '0;
    end else begin
      ack_q <= 1'b0;
      // A press for the crosswalk already walking is dropped, not queued.
      if (i_ped_req_a && !(state == S_PED_WALK && grant == 1'b0)) pend_a <= 1'b1;
      if (i_ped_req_b && !(state == S_PED_WALK && grant == 1'b1)) pend_b <= 1'b1;
`ifdef TRAFFIC_SCHED_EMERG_EN
      if (i_emerg) begin
        state <= S_EMERG;
        count <= '0;
      end else
`endif
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            state <= S_PED_WAIT;
            grant <= (pend_a && pend_b) ? rr_ptr : pend_b;
            count <= WAIT_LD;
          end else if (i_rush_req) begin
            state <= S_RUSH;
            count <= RUSH_LD;
          end
        end
        S_PED_WAIT: begin
          if (light_sel == LIGHT_RED) begin
            state <= S_PED_WALK;
            count <= WALK_LD;
            ack_q <= 1'b1;
          end else if (count == '0) begin
            state <= S_COOL;
            count <= COOL_LD;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        S_PED_WALK: begin
          if (count == '0) begin
            state  <= S_COOL;
            count  <= COOL_LD;
            rr_ptr <= ~rr_ptr;
            if (grant) pend_b <= 1'b0;
            else       pend_a <= 1'b0;
          end else begin
            count <= count - CNT_ONE;
          end
        end
        S_RUSH: begin
          if (!i_rush_req || (any_pend && count == '0)) begin
            state <= S_COOL;
            count <= COOL_LD;
          end else if (count != '0) begin
            count <= count - CNT_ONE;
          end
        end
        S_COOL: begin
          if (count == '0) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            count <= count - CNT_ONE;
          end
        end
`ifdef TRAFFIC_SCHED_EMERG_EN
        S_EMERG: begin
          state <= S_COOL;
          count <= COOL_LD;
        end
`endif
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign o_mode_p = (state == S_PED_WAIT) || (state == S_PED_WALK) || (state == S_EMERG);
  assign o_mode_r = (state == S_RUSH);
  assign o_walk_a = (state == S_PED_WALK) && !grant;
  assign o_walk_b = (state == S_PED_WALK) && grant;
  assign o_ack_a  = ack_q && !grant;
  assign o_ack_b  = ack_q && grant;
  assign o_busy   = (state != S_IDLE);
  assign o_state  = state;

endmodule

// File: tb/tb_traffic_sched.sv
// Directed bench for traffic_sched: walks, round-robin, abort/retry, rush pre-emption,
// async reset and (when compiled in) the emergency override.
module tb_traffic_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_WALK = 3'd2;
  localparam logic [2:0] ST_RUSH = 3'd3;
  localparam logic [2:0] ST_COOL = 3'd4;
  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] GREEN   = 2'b10;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_ped_req_a = 1'b0;
  logic       i_ped_req_b = 1'b0;
  logic       i_rush_req = 1'b0;
  logic [1:0] i_light_a = RED;
  logic [1:0] i_light_b = RED;
`ifdef TRAFFIC_SCHED_EMERG_EN
  logic       i_emerg = 1'b0;
`endif
  logic       o_mode_p, o_mode_r, o_walk_a, o_walk_b, o_ack_a, o_ack_b, o_busy;
  logic [2:0] o_state;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  traffic_sched dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_ped_req_a(i_ped_req_a),
    .i_ped_req_b(i_ped_req_b),
    .i_rush_req (i_rush_req),
`ifdef TRAFFIC_SCHED_EMERG_EN
    .i_emerg    (i_emerg),
`endif
    .i_light_a  (i_light_a),
    .i_light_b  (i_light_b),
    .o_mode_p   (o_mode_p),
    .o_mode_r   (o_mode_r),
    .o_walk_a   (o_walk_a),
    .o_walk_b   (o_walk_b),
    .o_ack_a    (o_ack_a),
    .o_ack_b    (o_ack_b),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    i_rstn = 1'b0;
    i_ped_req_a = 1'b0;
    i_ped_req_b = 1'b0;
    i_rush_req = 1'b0;
    i_light_a = RED;
    i_light_b = RED;
    repeat (2) tick();
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic press(input logic side);
    if (side) i_ped_req_b = 1'b1;
    else      i_ped_req_a = 1'b1;
    tick();
    i_ped_req_a = 1'b0;
    i_ped_req_b = 1'b0;
  endtask

  // Precondition: DUT in PED_WAIT with the granted light already RED.
  // Leaves the DUT in its last COOL cycle.
  task automatic expect_walk(input logic side, input bit press_same);
    tick();
    chk("walk_entry_ack", side ? o_ack_b : o_ack_a, 1);
    chk("walk_entry_lamp", side ? o_walk_b : o_walk_a, 1);
    chk("walk_other_lamp", side ? o_walk_a : o_walk_b, 0);
    chk("walk_mode_p", o_mode_p, 1);
    for (int i = 1; i < 8; i++) begin
      if (press_same && i == 3) begin
        if (side) i_ped_req_b = 1'b1;
        else      i_ped_req_a = 1'b1;
      end
      tick();
      i_ped_req_a = 1'b0;
      i_ped_req_b = 1'b0;
      chk("walk_hold", side ? o_walk_b : o_walk_a, 1);
      chk("walk_ack_once", side ? o_ack_b : o_ack_a, 0);
    end
    tick();
    chk("walk_end_state", o_state, ST_COOL);
    chk("walk_end_lamp", side ? o_walk_b : o_walk_a, 0);
    chk("cool_mode_p", o_mode_p, 0);
    repeat (3) begin
      tick();
      chk("cool_hold", o_state, ST_COOL);
    end
  endtask

  initial begin
    logic side;

    // Reset values
    i_rstn = 1'b0;
    tick();
    chk("rst_state", o_state, ST_IDLE);
    chk("rst_busy", o_busy, 0);
    chk("rst_mode_p", o_mode_p, 0);
    chk("rst_mode_r", o_mode_r, 0);
    chk("rst_walk", {o_walk_a, o_walk_b, o_ack_a, o_ack_b}, 0);
    reset_dut();

    // Single A request: one-cycle pend latency, full walk, cool, re-press ignored
    press(1'b0);
    chk("t1_pend_idle", o_state, ST_IDLE);
    tick();
    chk("t1_wait", o_state, ST_WAIT);
    chk("t1_mode_p", o_mode_p, 1);
    chk("t1_no_walk", o_walk_a, 0);
    expect_walk(1'b0, 1'b1);
    tick();
    chk("t1_idle", o_busy, 0);
    tick();
    chk("t1_repress_ignored", o_busy, 0);

    // Simultaneous A and B from reset: A first, B on next IDLE pass
    reset_dut();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    i_ped_req_a = 1'b1;
    i_ped_req_b = 1'b1;
    tick();
    i_ped_req_a = 1'b0;
    i_ped_req_b = 1'b0;
    tick();
    chk("t2_wait1", o_state, ST_WAIT);
    side = exp_q.pop_front();
    expect_walk(side, 1'b0);
    tick();
    chk("t2_idle_between", o_state, ST_IDLE);
    tick();
    chk("t2_wait2", o_state, ST_WAIT);
    side = exp_q.pop_front();
    expect_walk(side, 1'b0);
    tick();
    chk("t2_idle_end", o_busy, 0);

    // B request against a GREEN road: abort after 32 wait cycles, retry
    i_light_b = GREEN;
    press(1'b1);
    tick();
    for (int i = 0; i < 32; i++) begin
      chk("t3_waiting", o_state, ST_WAIT);
      chk("t3_no_walk", o_walk_b, 0);
      tick();
    end
    chk("t3_abort_cool", o_state, ST_COOL);
    repeat (3) begin
      tick();
      chk("t3_cool_hold", o_state, ST_COOL);
    end
    tick();
    chk("t3_idle", o_state, ST_IDLE);
    tick();
    chk("t3_retry_wait", o_state, ST_WAIT);
    tick();
    chk("t3_still_wait", o_state, ST_WAIT);
    chk("t3_still_no_walk", o_walk_b, 0);
    i_light_b = RED;
    expect_walk(1'b1, 1'b0);
    tick();
    chk("t3_done", o_busy, 0);

    // Rush with a pedestrian arriving in cycle 5: rush held 16 cycles minimum
    i_rush_req = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t4_rush", o_mode_r, 1);
      chk("t4_rush_no_p", o_mode_p, 0);
      if (i == 4) i_ped_req_a = 1'b1;
      tick();
      i_ped_req_a = 1'b0;
    end
    chk("t4_preempt_cool", o_state, ST_COOL);
    chk("t4_mode_r_off", o_mode_r, 0);
    repeat (3) tick();
    tick();
    chk("t4_idle", o_state, ST_IDLE);
    tick();
    chk("t4_ped_beats_rush", o_state, ST_WAIT);
    chk("t4_exclusive", o_mode_r, 0);
    expect_walk(1'b0, 1'b0);
    tick();
    chk("t4_idle2", o_state, ST_IDLE);
    tick();
    chk("t4_rush_again", o_mode_r, 1);
    i_rush_req = 1'b0;
    tick();
    chk("t4_drop_cool", o_state, ST_COOL);
    chk("t4_drop_mode_r", o_mode_r, 0);
    repeat (3) tick();
    tick();
    chk("t4_final_idle", o_busy, 0);

    // Async reset mid-walk with B pending: everything clears at once
    press(1'b0);
    tick();
    tick();
    chk("t5_walking", o_walk_a, 1);
    press(1'b1);
    #3 i_rstn = 1'b0;
    #1;
    chk("t5_async_walk", o_walk_a, 0);
    chk("t5_async_mode_p", o_mode_p, 0);
    chk("t5_async_busy", o_busy, 0);
    tick();
    i_rstn = 1'b1;
    tick();
    chk("t5_idle", o_state, ST_IDLE);
    tick();
    chk("t5_pend_cleared", o_state, ST_IDLE);

`ifdef TRAFFIC_SCHED_EMERG_EN
    // Emergency during B walk: walk dropped, pend kept, B re-served
    press(1'b1);
    tick();
    tick();
    chk("t6_walking", o_walk_b, 1);
    tick();
    i_emerg = 1'b1;
    tick();
    chk("t6_emerg_state", o_state, 3'd5);
    chk("t6_emerg_walk", o_walk_b, 0);
    chk("t6_emerg_mode_p", o_mode_p, 1);
    tick();
    chk("t6_emerg_hold", o_state, 3'd5);
    i_emerg = 1'b0;
    tick();
    chk("t6_release_cool", o_state, ST_COOL);
    repeat (3) tick();
    tick();
    chk("t6_idle", o_state, ST_IDLE);
    tick();
    chk("t6_reserve", o_state, ST_WAIT);
    expect_walk(1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
